// File: rtl/encoder_pkg.sv
// encoder_pkg: shared constants, FSM state type and one-hot helper for
// the encoder_42_arb request encoder.
package encoder_pkg;

    localparam int ENC_N = 4;
    localparam int ENC_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_t;

    // One-hot expansion of a line index; bit idx is the only bit set.
    function automatic logic [ENC_N-1:0] onehot(input logic [ENC_W-1:0] idx);
        logic [ENC_N-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/enc_pri_sel.sv
// enc_pri_sel: combinational selector. Starting at index 'start' and
// descending modulo N, returns the first set bit of vec. With start tied
// to N-1 this is plain highest-index priority.
module enc_pri_sel
    import encoder_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] pos;

    // Walk downward from start; N is a power of two so W-bit wrap is mod N.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = start;
        for (int o = 0; o < N; o++) begin
            pos = start - W'(o);
            if (!any && vec[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_42_arb.sv
// encoder_42_arb: collects request lines into a sticky pending set and
// hands out one binary line index per valid/ready handshake.
// Optional macro ENCODER_ROUND_ROBIN_EN replaces fixed highest-index
// priority with a rotating search pointer.
//
// state | meaning
// IDLE  | nothing presented, valid=0
// HOLD  | code presented and held until accepted, valid=1
module encoder_42_arb
    import encoder_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         merged
);

    enc_state_t   state;
    logic         ack;
    logic [N-1:0] code_oh;
    logic [N-1:0] ack_mask;
    logic [N-1:0] pending_nxt;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_any;

    assign valid = (state == HOLD);
    assign ack   = valid & ready;

    if (N == ENC_N && W == ENC_W) begin : g_oh_pkg
        assign code_oh = onehot(code);
    end else begin : g_oh_gen
        // Generic one-hot of the presented code for non-default sizes.
        always_comb begin
            code_oh       = '0;
            code_oh[code] = 1'b1;
        end
    end

    assign ack_mask    = ack ? code_oh : '0;
    // A fresh request on the line being acknowledged keeps its bit set.
    assign pending_nxt = (pending & ~ack_mask) | (en ? req : '0);

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    // The search for the next code already uses the post-ack pointer, so the
    // line just granted is lowest priority for the back-to-back load.
    assign start = ack ? (code - W'(1)) : ptr;

    // Rotate the pointer past each granted line; hold it while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= W'(N - 1);
        end else if (ack) begin
            ptr <= code - W'(1);
        end
    end
`else
    assign start = W'(N - 1);
`endif

    enc_pri_sel #(
        .N (N),
        .W (W)
    ) u_sel (
        .vec   (pending_nxt),
        .start (start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Pending set, coalesce flag and presentation FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            code    <= '0;
            merged  <= 1'b0;
            state   <= IDLE;
        end else begin
            pending <= pending_nxt;
            merged  <= en & (|(req & pending & ~ack_mask));
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        code  <= sel_idx;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // Code stays put until accepted; no preemption.
                    if (ack) begin
                        if (sel_any) begin
                            code <= sel_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/encoder_42_arb.md
Name: encoder_42_arb

Overview:
- Inverse partner of the team's 2-to-4 decoder. Collects up to N request lines, whether one-hot or multi-hot, into a sticky pending set.
- Emits one binary code per request over a valid/ready handshake.
- Code bit W-1 is the MSB, so code 2'b11 names line 3. This matches decoder output y3, so a downstream decoder reproduces the original line.

Parameters:
- N, 4, number of request lines (power of two, 2..16).
- W, 2, code width; must equal log2(N).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, request-capture enable. When en=0, req is ignored but draining continues.
- req, input, N, request pulses or levels, sampled every edge while en=1.
- code, output, W, registered index of the granted line.
- valid, output, 1, code is valid.
- ready, input, 1, consumer accepts code when valid=1 and ready=1.
- pending, output, N, registered pending set, for debug and status.
- merged, output, 1, one-cycle pulse: a sampled req bit was already pending and was coalesced.

Behaviour:
- Reset (rst=1 at an edge): pending=0, code=0, valid=0, merged=0, state=IDLE. Reset overrides all other inputs, including in-flight handshakes.
- ack = valid & ready; ack_mask = one-hot(code) when ack=1, else 0.
- pending_nxt = (pending & ~ack_mask) | (en ? req : 0). A new req on the line being acknowledged in the same cycle wins: the bit stays set.
- Selection, fixed priority: highest set index of pending_nxt.
- States:
  - IDLE (valid=0). If pending_nxt != 0, load code = sel(pending_nxt), set valid=1, go to HOLD. Latency: req high at edge t gives valid=1 in the cycle after edge t.
  - HOLD (valid=1). Code is held stable while ready=0; a higher-priority arrival never preempts a presented code.
    - On ack with pending_nxt != 0: load the next code at the same edge and stay in HOLD. This gives back-to-back, one code per cycle.
    - On ack with pending_nxt == 0: valid=0, go to IDLE. Code keeps its last value.
- merged = en & |(req & pending & ~ack_mask), registered, so it is a one-cycle pulse after the sampling edge.
- All N lines set: drains in N consecutive acks, in order N-1 down to 0.
- req held high as a level re-arms its bit every cycle, so that line is never starved out of pending. Under fixed priority it can still starve lower lines.
- en low mid-operation: no new bits enter; existing pending bits drain normally.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Adds a W-bit pointer ptr, reset to N-1.
  - Search starts at ptr and descends modulo N; the first set bit wins.
  - On each ack of index k, ptr <= (k-1) mod N, so the granted line becomes lowest priority.
  - ptr is unchanged while idle.
- Undefined: no ptr register; fixed highest-index priority as above.

Decomposition:
- Package encoder_pkg holds:
  - constants ENC_N=4 and ENC_W=2;
  - state typedef enc_state_t {IDLE, HOLD};
  - function onehot(idx).
- One sub-module, enc_pri_sel: purely combinational. Inputs are vec[N] and start[W] (start tied to N-1 without the macro). Outputs are idx[W] and any.
- Top level keeps pending, state, code, ptr and merged registers.

Test Plan:
- Reset mid-HOLD: pending=4'b1010, valid=1, assert rst for one edge -> next cycle pending=0, valid=0, code=0, merged=0.
- Single request: req=4'b0100 for 1 cycle, ready=1 -> valid=1 with code=2'b10 exactly one cycle later; valid=0 the following cycle.
- Multi-hot drain with backpressure: req=4'b1011 for 1 cycle, ready=0 for 3 cycles, then ready=1:
  - code holds 2'b11 through the stall;
  - then 2'b01 and 2'b00 on consecutive cycles;
  - then valid=0.
- Simultaneous ack and re-request: presenting code=2'b11, ready=1, req=4'b1000 -> pending[3] stays 1, next code=2'b11, merged=0.
- Coalesce and en gating:
  - req=4'b0001 while pending[0]=1 -> merged pulses 1 for one cycle;
  - en=0 with req=4'b0010 -> pending unchanged.
- ENCODER_ROUND_ROBIN_EN:
  - req=4'b1001 held high continuously, ready=1 -> codes alternate 3,0,3,0.
  - Same stimulus with the macro undefined -> code stays 3 every cycle.
